evaluate: RTL and testbench
===========================

# evaluate

Output-end evaluation unit for an `associate` chain. Consumes the signed result stream and thresholds it to a binary activation. In training mode it also joins the result with a target stream and returns the signed error (target − activation) to the unit's error input, closing the result→error loop. A saturating miss counter reports nonzero errors for convergence checks.

## Interface
- `RESW`, 16, result and target data width (signed)
- `ERRW`, 16, error data width (signed)
- `ACTW`, 16, activation data width
- `HIGH`, 16'h00ff, activation value for non-negative result; low value is 0
- `MISW`, 16, miss counter width
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  training enable; sampled on result handshake
- `clr`  in  1  synchronous miss-counter clear
- `res_valid` / `res_ready` / `res_data`  in / out / in  1 / 1 / RESW  result stream (slave)
- `tgt_valid` / `tgt_ready` / `tgt_data`  in / out / in  1 / 1 / RESW  target stream (slave)
- `act_valid` / `act_ready` / `act_data`  out / in / out  1 / 1 / ACTW  activation stream (master)
- `err_valid` / `err_ready` / `err_data`  out / in / out  1 / 1 / ERRW  error stream (master)
- `miss`  out  MISW  count of nonzero errors, saturating

## Operation
- All streams: a transfer occurs on a rising `clk` edge with valid && ready. Once asserted, a master valid and its data hold until the transfer.
- FSM states: `IDLE`, `TARGET`, `OUTPUT`.
- `IDLE`:
  - `res_ready`=1.
  - On a result handshake, register `res_data` and `mode`=`en`.
  - `mode`=1 → `TARGET`; `mode`=0 → `OUTPUT`.
- `TARGET`:
  - `tgt_ready`=1.
  - On a target handshake, register `tgt_data` and go to `OUTPUT`.
  - `tgt_ready` is 0 in all other states.
- Activation: `act` = `HIGH` if `$signed(res)` < 0 is false, else 0. Result 0 gives `HIGH`.
- Error:
  - `tgt − act` is computed at max(RESW,ACTW)+1 bits, both operands sign-extended.
  - The difference is saturated to the signed ERRW range [−2^(ERRW−1), 2^(ERRW−1)−1].
- `OUTPUT`:
  - `act_valid`=1. `err_valid`=`mode`.
  - Each stream's handshake clears its own pending flag; they may complete in the same or different cycles.
  - When no flag remains pending → `IDLE`.
- Miss counter:
  - Increments by 1 on an error handshake with `err_data` ≠ 0.
  - Saturates at all-ones.
  - `clr` sets it to 0 and has priority over the increment in the same cycle.
- Changing `en` mid-transaction has no effect; `mode` is latched per transaction.

## Timing
- Reset values: state=`IDLE`; `res_ready`=1 (combinational from state); `tgt_ready`=0; `act_valid`=0, `err_valid`=0; `act_data`=0, `err_data`=0; `miss`=0.
- Reset mid-transaction discards the captured result and target without emitting anything.
- Latency:
  - `act_valid` rises 1 cycle after the result handshake when `mode`=0.
  - `act_valid` and `err_valid` rise 1 cycle after the target handshake when `mode`=1.
- Throughput:
  - Inference: 1 result per 2 cycles with sinks always ready.
  - Training: 1 per 3 cycles.
- `res_ready` is 0 in `TARGET` and `OUTPUT`. No new result is accepted before both outputs of the previous transaction have transferred.
- `tgt_valid` asserted while in `IDLE` is held off (not consumed) until `TARGET`.
- Sink backpressure: `act_ready`=0 or `err_ready`=0 holds the FSM in `OUTPUT` indefinitely, with data stable.

## Structure
- Shared package `evaluate_pkg`:
  - `state_t` enum {`IDLE`, `TARGET`, `OUTPUT`}.
  - Default `HIGH` constant.
  - Function `sat(value, width)` for signed saturation.
- One sub-module, `saturate` (parameters `INW`, `OUTW`): signed clamp, reusable for the error path and elsewhere.
- Everything else, including the FSM, activation, counter and registers, lives in `evaluate`.

## Test plan
- Inference: `en`=0, result 16'h8000 → activation 16'h0000 after 1 cycle, no `err_valid`, `tgt_ready` never asserted. Result 16'h0000 → activation 16'h00ff.
- Training: `en`=1, result 16'hfff0, target 16'h00ff → activation 0, error 16'h00ff, `miss`=1. Result 16'h0005, target 16'h00ff → error 0, `miss` unchanged.
- Saturation: `ERRW`=8, `en`=1, result 16'h0001, target 16'h8000 → error 8'h80 (−128), not a wrapped value.
- Backpressure: hold `err_ready`=0 for 5 cycles with `act_ready`=1 → activation transfers once, error is held stable, `res_ready`=0 throughout, and the FSM returns to `IDLE` the cycle after the error transfers.
- Reset: assert `rst` while in `TARGET` → all valids 0, `res_ready`=1, `miss`=0. The next transaction with result 16'h0000 and target 16'h0000 gives error 16'hff01.
- Counter: `MISW`=2, four nonzero errors → `miss`=3. `clr` asserted in the same cycle as a fifth nonzero error handshake → `miss`=0.

Source files
------------

// File: rtl/evaluate_pkg.sv
// Shared types, constants and helpers for the evaluate output stage.
package evaluate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TARGET = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic [15:0] HIGH_DEFAULT = 16'h00ff;

  // Clamp a signed value to the signed range of the given bit width (1..64).
  function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                             input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/evaluate_saturate.sv
// Signed clamp from INW bits down (or up) to OUTW bits.
module saturate
  import evaluate_pkg::*;
#(
  parameter int unsigned INW  = 17,
  parameter int unsigned OUTW = 16
) (
  input  logic [INW-1:0]  in_i,
  output logic [OUTW-1:0] out_o
);

  logic signed [63:0] wide;

  assign wide  = 64'($signed(in_i));
  assign out_o = OUTW'(sat(wide, OUTW));

endmodule

// File: rtl/evaluate.sv
// Thresholds a result stream to a binary activation and, in training mode,
// returns the saturated error (target - activation) and counts misses.
module evaluate
  import evaluate_pkg::*;
#(
  parameter int unsigned     RESW = 16,
  parameter int unsigned     ERRW = 16,
  parameter int unsigned     ACTW = 16,
  parameter logic [ACTW-1:0] HIGH = ACTW'(HIGH_DEFAULT),
  parameter int unsigned     MISW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic [RESW-1:0] res_data_i,
  input  logic            tgt_valid_i,
  output logic            tgt_ready_o,
  input  logic [RESW-1:0] tgt_data_i,
  output logic            act_valid_o,
  input  logic            act_ready_i,
  output logic [ACTW-1:0] act_data_o,
  output logic            err_valid_o,
  input  logic            err_ready_i,
  output logic [ERRW-1:0] err_data_o,
  output logic [MISW-1:0] miss_o
);

  localparam int unsigned DW = ((RESW > ACTW) ? RESW : ACTW) + 1;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic            act_pend_q, act_pend_d;
  logic            err_pend_q, err_pend_d;
  logic [ACTW-1:0] act_data_q, act_data_d;
  logic [ERRW-1:0] err_data_q, err_data_d;
  logic [MISW-1:0] miss_q, miss_d;

  logic            res_hs, tgt_hs, act_hs, err_hs;
  logic [DW-1:0]   tgt_ext, act_ext, diff;
  logic [ERRW-1:0] err_sat;

  assign res_ready_o = (state_q == IDLE);
  assign tgt_ready_o = (state_q == TARGET);
  assign act_valid_o = act_pend_q;
  assign err_valid_o = err_pend_q;
  assign act_data_o  = act_data_q;
  assign err_data_o  = err_data_q;
  assign miss_o      = miss_q;

  assign res_hs = res_valid_i & res_ready_o;
  assign tgt_hs = tgt_valid_i & tgt_ready_o;
  assign act_hs = act_pend_q & act_ready_i;
  assign err_hs = err_pend_q & err_ready_i;

  // The activation is latched at result time, so the error uses act_data_q.
  assign tgt_ext = DW'($signed(tgt_data_i));
  assign act_ext = DW'($signed(act_data_q));
  assign diff    = tgt_ext - act_ext;

  saturate #(
    .INW  (DW),
    .OUTW (ERRW)
  ) u_err_sat (
    .in_i  (diff),
    .out_o (err_sat)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    act_pend_d = act_pend_q;
    err_pend_d = err_pend_q;
    act_data_d = act_data_q;
    err_data_d = err_data_q;
    unique case (state_q)
      IDLE: begin
        if (res_hs) begin
          mode_d     = en_i;
          act_data_d = res_data_i[RESW-1] ? '0 : HIGH;
          if (en_i) begin
            state_d = TARGET;
          end else begin
            act_pend_d = 1'b1;
            state_d    = OUTPUT;
          end
        end
      end
      TARGET: begin
        if (tgt_hs) begin
          err_data_d = err_sat;
          act_pend_d = 1'b1;
          err_pend_d = mode_q;
          state_d    = OUTPUT;
        end
      end
      OUTPUT: begin
        if (act_hs) act_pend_d = 1'b0;
        if (err_hs) err_pend_d = 1'b0;
        if (!act_pend_d && !err_pend_d) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        act_pend_d = 1'b0;
        err_pend_d = 1'b0;
      end
    endcase
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    miss_d = miss_q;
    if (clr_i) begin
      miss_d = '0;
    end else if (err_hs && (err_data_q != '0) && (miss_q != '1)) begin
      miss_d = miss_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      act_pend_q <= 1'b0;
      err_pend_q <= 1'b0;
      act_data_q <= '0;
      err_data_q <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      act_pend_q <= act_pend_d;
      err_pend_q <= err_pend_d;
      act_data_q <= act_data_d;
      err_data_q <= err_data_d;
      miss_q     <= miss_d;
    end
  end

endmodule

// File: tb/tb_evaluate.sv
// Directed self-checking bench for evaluate: a 16-bit unit with a 2-bit miss
// counter, plus an 8-bit-error instance for the saturation case.
module tb_evaluate;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance (MISW=2)
  logic        en = 1'b0, clr = 1'b0;
  logic        res_valid = 1'b0, tgt_valid = 1'b0;
  logic [15:0] res_data = '0, tgt_data = '0;
  logic        act_ready = 1'b1, err_ready = 1'b1;
  logic        res_ready, tgt_ready, act_valid, err_valid;
  logic [15:0] act_data, err_data;
  logic [1:0]  miss;

  evaluate #(.MISW(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr),
    .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
    .tgt_valid_i(tgt_valid), .tgt_ready_o(tgt_ready), .tgt_data_i(tgt_data),
    .act_valid_o(act_valid), .act_ready_i(act_ready), .act_data_o(act_data),
    .err_valid_o(err_valid), .err_ready_i(err_ready), .err_data_o(err_data),
    .miss_o(miss)
  );

  // Saturation instance (ERRW=8)
  logic        en8 = 1'b1, clr8 = 1'b0;
  logic        res_valid8 = 1'b0, tgt_valid8 = 1'b0;
  logic [15:0] res_data8 = '0, tgt_data8 = '0;
  logic        act_ready8 = 1'b1, err_ready8 = 1'b1;
  logic        res_ready8, tgt_ready8, act_valid8, err_valid8;
  logic [15:0] act_data8;
  logic [7:0]  err_data8;
  logic [15:0] miss8;

  evaluate #(.ERRW(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .en_i(en8), .clr_i(clr8),
    .res_valid_i(res_valid8), .res_ready_o(res_ready8), .res_data_i(res_data8),
    .tgt_valid_i(tgt_valid8), .tgt_ready_o(tgt_ready8), .tgt_data_i(tgt_data8),
    .act_valid_o(act_valid8), .act_ready_i(act_ready8), .act_data_o(act_data8),
    .err_valid_o(err_valid8), .err_ready_i(err_ready8), .err_data_o(err_data8),
    .miss_o(miss8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: leaves the main DUT in OUTPUT with the results presented.
  task automatic drive_to_output(input logic e, input logic [15:0] r, input logic [15:0] t);
    en = e; res_valid = 1'b1; res_data = r;
    tick();
    res_valid = 1'b0;
    if (e) begin
      tgt_valid = 1'b1; tgt_data = t;
      tick();
      tgt_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL rst_res_ready got %b want 1", res_ready); end
    checks++; if (tgt_ready !== 1'b0) begin failures++; $display("FAIL rst_tgt_ready got %b want 0", tgt_ready); end
    checks++; if (act_valid !== 1'b0) begin failures++; $display("FAIL rst_act_valid got %b want 0", act_valid); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL rst_err_valid got %b want 0", err_valid); end
    checks++; if (act_data !== 16'h0000) begin failures++; $display("FAIL rst_act_data got %h want 0000", act_data); end
    checks++; if (err_data !== 16'h0000) begin failures++; $display("FAIL rst_err_data got %h want 0000", err_data); end
    checks++; if (miss !== 2'd0) begin failures++; $display("FAIL rst_miss got %0d want 0", miss); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_inference();
    logic [15:0] vec_r [2];
    logic [15:0] vec_a [2];
    vec_r[0] = 16'h8000; vec_a[0] = 16'h0000;
    vec_r[1] = 16'h0000; vec_a[1] = 16'h00ff;
    for (int i = 0; i < 2; i++) begin
      drive_to_output(1'b0, vec_r[i], 16'h0000);
      checks++; if (act_valid !== 1'b1) begin failures++; $display("FAIL inf_act_valid[%0d] got %b want 1", i, act_valid); end
      checks++; if (act_data !== vec_a[i]) begin failures++; $display("FAIL inf_act_data[%0d] got %h want %h", i, act_data, vec_a[i]); end
      checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL inf_err_valid[%0d] got %b want 0", i, err_valid); end
      checks++; if (tgt_ready !== 1'b0) begin failures++; $display("FAIL inf_tgt_ready[%0d] got %b want 0", i, tgt_ready); end
      checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL inf_res_ready_busy[%0d] got %b want 0", i, res_ready); end
      tick();
      checks++; if (act_valid !== 1'b0) begin failures++; $display("FAIL inf_act_done[%0d] got %b want 0", i, act_valid); end
      checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL inf_res_ready_idle[%0d] got %b want 1", i, res_ready); end
    end
  endtask

  task automatic test_training();
    // Target offered early must wait until the result has been taken.
    en = 1'b1; res_valid = 1'b1; res_data = 16'hfff0; tgt_valid = 1'b1; tgt_data = 16'h00ff;
    tick();
    res_valid = 1'b0;
    checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL trn_tgt_ready got %b want 1", tgt_ready); end
    checks++; if (act_valid !== 1'b0) begin failures++; $display("FAIL trn_act_early got %b want 0", act_valid); end
    tick();
    tgt_valid = 1'b0;
    checks++; if ({act_valid, err_valid} !== 2'b11) begin failures++; $display("FAIL trn_valids got %b want 11", {act_valid, err_valid}); end
    checks++; if (act_data !== 16'h0000) begin failures++; $display("FAIL trn_act_data got %h want 0000", act_data); end
    checks++; if (err_data !== 16'h00ff) begin failures++; $display("FAIL trn_err_data got %h want 00ff", err_data); end
    tick();
    checks++; if (miss !== 2'd1) begin failures++; $display("FAIL trn_miss1 got %0d want 1", miss); end
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL trn_idle got %b want 1", res_ready); end
    drive_to_output(1'b1, 16'h0005, 16'h00ff);
    checks++; if (act_data !== 16'h00ff) begin failures++; $display("FAIL trn_act_data2 got %h want 00ff", act_data); end
    checks++; if (err_data !== 16'h0000) begin failures++; $display("FAIL trn_err_zero got %h want 0000", err_data); end
    tick();
    checks++; if (miss !== 2'd1) begin failures++; $display("FAIL trn_miss_hold got %0d want 1", miss); end
  endtask

  task automatic test_saturation();
    res_valid8 = 1'b1; res_data8 = 16'h0001; tgt_valid8 = 1'b1; tgt_data8 = 16'h8000;
    tick();
    res_valid8 = 1'b0;
    tick();
    tgt_valid8 = 1'b0;
    checks++; if (err_valid8 !== 1'b1) begin failures++; $display("FAIL sat_err_valid got %b want 1", err_valid8); end
    checks++; if (err_data8 !== 8'h80) begin failures++; $display("FAIL sat_err_data got %h want 80", err_data8); end
    checks++; if (act_data8 !== 16'h00ff) begin failures++; $display("FAIL sat_act_data got %h want 00ff", act_data8); end
    tick();
    checks++; if (miss8 !== 16'd1) begin failures++; $display("FAIL sat_miss got %0d want 1", miss8); end
  endtask

  task automatic test_backpressure();
    int act_xfers = 0;
    err_ready = 1'b0;
    drive_to_output(1'b1, 16'hfff0, 16'h0001);
    if (act_valid && act_ready) act_xfers++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (act_valid && act_ready) act_xfers++;
      checks++; if (err_valid !== 1'b1) begin failures++; $display("FAIL bp_err_valid[%0d] got %b want 1", i, err_valid); end
      checks++; if (err_data !== 16'h0001) begin failures++; $display("FAIL bp_err_data[%0d] got %h want 0001", i, err_data); end
      checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL bp_res_ready[%0d] got %b want 0", i, res_ready); end
    end
    checks++; if (act_xfers != 1) begin failures++; $display("FAIL bp_act_xfers got %0d want 1", act_xfers); end
    err_ready = 1'b1;
    tick();
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL bp_idle got %b want 1", res_ready); end
    checks++; if (err_valid !== 1'b0) begin failures++; $display("FAIL bp_err_done got %b want 0", err_valid); end
    checks++; if (miss !== 2'd2) begin failures++; $display("FAIL bp_miss got %0d want 2", miss); end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; res_valid = 1'b1; res_data = 16'h7000;
    tick();
    res_valid = 1'b0;
    checks++; if (tgt_ready !== 1'b1) begin failures++; $display("FAIL rm_in_target got %b want 1", tgt_ready); end
    rst = 1'b1;
    #1;
    checks++; if ({act_valid, err_valid, tgt_ready} !== 3'b000) begin failures++; $display("FAIL rm_outputs got %b want 000", {act_valid, err_valid, tgt_ready}); end
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL rm_res_ready got %b want 1", res_ready); end
    checks++; if (miss !== 2'd0) begin failures++; $display("FAIL rm_miss got %0d want 0", miss); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({act_valid, err_valid} !== 2'b00) begin failures++; $display("FAIL rm_no_emit got %b want 00", {act_valid, err_valid}); end
    drive_to_output(1'b1, 16'h0000, 16'h0000);
    checks++; if (err_data !== 16'hff01) begin failures++; $display("FAIL rm_err_data got %h want ff01", err_data); end
    tick();
  endtask

  task automatic test_counter();
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (miss !== 2'd0) begin failures++; $display("FAIL cnt_clr got %0d want 0", miss); end
    for (int i = 0; i < 4; i++) begin
      drive_to_output(1'b1, 16'h0000, 16'h0000);
      tick();
      checks++; if (miss !== want[i]) begin failures++; $display("FAIL cnt_miss[%0d] got %0d want %0d", i, miss, want[i]); end
    end
    drive_to_output(1'b1, 16'h0000, 16'h0000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (miss !== 2'd0) begin failures++; $display("FAIL cnt_clr_prio got %0d want 0", miss); end
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL cnt_idle got %b want 1", res_ready); end
  endtask

  initial begin
    test_reset();
    test_inference();
    test_training();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
